// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares one picorv32-style native memory port among NREQ requesters, for
// example the scalar core fetch/LSU and the vector load/store unit. It sits
// upstream of the AXI adapter. Only one transaction is in flight at a time.
// The winner is chosen round-robin. The downstream request is registered and
// stays frozen until mem_ready, and the completion is then routed back to the
// winner.
//
// Parameters:
//   NREQ           number of requesters (>= 2)
//   TIMEOUT_CYCLES watchdog limit in BUSY cycles (watchdog build only)
//
// Build option:
//   MEM_REQ_ARBITER_WATCHDOG_EN  When defined, a BUSY transaction that sees no
//                                mem_ready for TIMEOUT_CYCLES cycles is force-
//                                completed with read data 32'hDEADBEEF, and
//                                timeout_err is set (sticky until reset).
//                                When undefined, BUSY waits indefinitely and
//                                timeout_err is tied to 0.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   req_valid/instr       per-requester request valid / instruction-fetch flag
//   req_addr/wdata        packed 32-bit fields, requester i at [32*i+31:32*i]
//   req_wstrb             packed 4-bit strobes, 0 = read
//   req_ready             one-hot completion pulse (combinational)
//   req_rdata             read data broadcast, qualified by req_ready
//   mem_valid/instr/addr/wdata/wstrb   registered downstream request
//   mem_ready/rdata       downstream completion and read data
//   grant                 one-hot current owner, 0 when idle
//   timeout_err           sticky watchdog error flag
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_instr,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_wstrb,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          req_rdata,
    output logic                 mem_valid,
    output logic                 mem_instr,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic [NREQ-1:0]      grant,
    output logic                 timeout_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_owner;
    logic [NREQ-1:0]  r_grant;
    logic             r_mem_valid;
    logic             r_mem_instr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;

    logic [IW-1:0]    w_win;
    logic             w_any;
    logic             w_done;
    logic             w_wd_fire;

    // Round-robin search. Offsets are visited from NREQ down to 1 so that the
    // last hit, which wins, is the nearest requester above r_last.
    always_comb begin
        int unsigned w_idx;
        w_win = '0;
        w_any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(r_last) + NREQ - k) % NREQ;
            if (req_valid[w_idx]) begin
                w_win = IW'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    // Watchdog
`ifdef MEM_REQ_ARBITER_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_timeout_err;

    assign w_wd_fire   = (r_state == S_BUSY) && (r_wd_cnt == 32'(TIMEOUT_CYCLES));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_wd_cnt <= '0;
            end else if (!mem_ready && !w_wd_fire) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (w_wd_fire && !mem_ready) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_wd_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and completion outputs
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        req_ready   = '0;
        req_rdata   = mem_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready || w_wd_fire) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A transaction abandoned by reset must not signal completion.
        if (w_done && resetn) begin
            req_ready = r_grant;
        end
        if (w_wd_fire && !mem_ready) begin
            req_rdata = 32'hDEAD_BEEF;
        end
    end

    // Downstream request registers and ownership tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_grant     <= '0;
            r_owner     <= '0;
            r_last      <= IW'(NREQ - 1);
        end else begin
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_mem_valid <= 1'b1;
                    r_mem_instr <= req_instr[w_win];
                    r_mem_addr  <= req_addr[w_win*32 +: 32];
                    r_mem_wdata <= req_wdata[w_win*32 +: 32];
                    r_mem_wstrb <= req_wstrb[w_win*4 +: 4];
                    r_grant     <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    r_owner     <= w_win;
                end
            end else if (w_done) begin
                r_mem_valid <= 1'b0;
                r_grant     <= '0;
                r_last      <= r_owner;
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_instr = r_mem_instr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign grant     = r_grant;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Directed scoreboard bench for mem_req_arbiter (NREQ=2, TIMEOUT_CYCLES=16).
// Stimulus pushes the expected downstream request and the expected completion
// into queues; a negedge monitor pops and compares whenever mem_valid rises or
// req_ready pulses, and checks that mem_* stay frozen while mem_valid is high.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

    localparam int unsigned NREQ = 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_instr;
    logic [NREQ*32-1:0]   req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_wstrb;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          req_rdata;
    logic                 mem_valid;
    logic                 mem_instr;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;
    logic [NREQ-1:0]      grant;
    logic                 timeout_err;

    mem_req_arbiter #(
        .NREQ          (NREQ),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_instr  (req_instr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_ready  (req_ready),
        .req_rdata  (req_rdata),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      wstrb;
        logic            instr;
    } req_t;

    typedef struct packed {
        logic [NREQ-1:0] ready;
        logic [31:0]     rdata;
    } cpl_t;

    req_t exp_req[$];
    cpl_t exp_cpl[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input int r);
        req_t t;
        t.g     = '0;
        t.g[r]  = 1'b1;
        t.addr  = req_addr[32*r +: 32];
        t.wdata = req_wdata[32*r +: 32];
        t.wstrb = req_wstrb[4*r +: 4];
        t.instr = req_instr[r];
        return t;
    endfunction

    // Monitor / scoreboard
    logic       mv_prev = 1'b0;
    logic [68:0] snap;

    always @(negedge clk) begin
        req_t e;
        cpl_t c;
        if (mem_valid && !mv_prev) begin
            if (exp_req.size() == 0) begin
                chk("req_unexpected", 128'(mem_valid), 128'd0);
            end else begin
                e = exp_req.pop_front();
                chk("grant",     128'(grant),     128'(e.g));
                chk("mem_addr",  128'(mem_addr),  128'(e.addr));
                chk("mem_wdata", 128'(mem_wdata), 128'(e.wdata));
                chk("mem_wstrb", 128'(mem_wstrb), 128'(e.wstrb));
                chk("mem_instr", 128'(mem_instr), 128'(e.instr));
            end
            snap = {mem_instr, mem_wstrb, mem_wdata, mem_addr};
        end else if (mem_valid) begin
            chk("mem_frozen", 128'({mem_instr, mem_wstrb, mem_wdata, mem_addr}), 128'(snap));
        end
        if (req_ready != '0) begin
            if (exp_cpl.size() == 0) begin
                chk("ready_unexpected", 128'(req_ready), 128'd0);
            end else begin
                c = exp_cpl.pop_front();
                chk("req_ready", 128'(req_ready), 128'(c.ready));
                chk("req_rdata", 128'(req_rdata), 128'(c.rdata));
            end
        end
        mv_prev = mem_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
    endtask

    // Called one cycle after the grant edge; asserts mem_ready in BUSY cycle
    // number dly, then drops the requesters in drop.
    task automatic complete(input int dly, input logic [31:0] rd,
                            input logic [NREQ-1:0] who, input logic [NREQ-1:0] drop);
        repeat (dly - 1) tick;
        mem_ready = 1'b1;
        mem_rdata = rd;
        exp_cpl.push_back('{ready: who, rdata: rd});
        tick;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        req_valid = req_valid & ~drop;
        chk("bubble_mem_valid", 128'(mem_valid), 128'd0);
        chk("bubble_grant",     128'(grant),     128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_instr = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) tick;

        // Reset state
        chk("rst_mem_valid",   128'(mem_valid),   128'd0);
        chk("rst_grant",       128'(grant),       128'd0);
        chk("rst_req_ready",   128'(req_ready),   128'd0);
        chk("rst_timeout_err", 128'(timeout_err), 128'd0);
        chk("rst_mem_addr",    128'(mem_addr),    128'd0);
        chk("rst_mem_wstrb",   128'(mem_wstrb),   128'd0);
        resetn = 1'b1;
        tick;

        // Single read by requester 0, ready in third BUSY cycle
        req_addr[31:0]  = 32'h0000_0100;
        req_wdata[31:0] = 32'h0;
        req_wstrb[3:0]  = 4'h0;
        req_instr[0]    = 1'b1;
        req_valid       = 2'b01;
        exp_req.push_back(mk(0));
        tick;
        chk("latency_mem_valid", 128'(mem_valid), 128'd1);
        complete(3, 32'h1234_5678, 2'b01, 2'b01);

        // Both held: 01,10,01,10 with bubbles
        do_reset;
        req_addr   = {32'h0000_2000, 32'h0000_1000};
        req_wdata  = {32'h55AA_55AA, 32'h0000_0000};
        req_wstrb  = {4'hF, 4'h0};
        req_instr  = 2'b00;
        req_valid  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(mk(i % 2));
            tick;
            complete(1, 32'hA000_0000 + 32'(i), (i % 2 == 0) ? 2'b01 : 2'b10,
                     (i == 3) ? 2'b11 : 2'b00);
        end

        // Requester 1 write; requester 0 arrives mid-BUSY and must wait
        req_addr[63:32]  = 32'h0000_0200;
        req_wdata[63:32] = 32'hCAFE_F00D;
        req_wstrb[7:4]   = 4'b0011;
        req_valid        = 2'b10;
        exp_req.push_back(mk(1));
        tick;
        tick;
        req_addr[31:0]  = 32'h0000_0300;
        req_wdata[31:0] = 32'h1111_2222;
        req_wstrb[3:0]  = 4'hF;
        req_valid       = 2'b11;
        tick;
        chk("busy_grant", 128'(grant), 128'(2'b10));
        tick;
        complete(1, 32'h0BAD_F00D, 2'b10, 2'b10);
        exp_req.push_back(mk(0));
        tick;
        complete(2, 32'h0000_0003, 2'b01, 2'b01);

        // Spurious mem_ready while idle; pointer must be unchanged afterwards
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        repeat (3) begin
            tick;
            chk("idle_req_ready", 128'(req_ready), 128'd0);
            chk("idle_mem_valid", 128'(mem_valid), 128'd0);
            chk("idle_grant",     128'(grant),     128'd0);
        end
        mem_ready = 1'b0;
        req_valid = 2'b11;
        exp_req.push_back(mk(1));
        tick;
        complete(2, 32'h0000_0044, 2'b10, 2'b10);
        exp_req.push_back(mk(0));
        tick;
        complete(1, 32'h0000_0055, 2'b01, 2'b01);

        // Reset during BUSY
        req_valid = 2'b10;
        exp_req.push_back(mk(1));
        tick;
        tick;
        resetn = 1'b0;
        tick;
        chk("midrst_mem_valid", 128'(mem_valid), 128'd0);
        chk("midrst_grant",     128'(grant),     128'd0);
        chk("midrst_req_ready", 128'(req_ready), 128'd0);
        resetn    = 1'b1;
        req_valid = 2'b11;
        exp_req.push_back(mk(0));
        tick;
        complete(1, 32'h0000_0066, 2'b01, 2'b01);
        exp_req.push_back(mk(1));
        tick;
        complete(1, 32'h0000_0077, 2'b10, 2'b10);

`ifdef MEM_REQ_ARBITER_WATCHDOG_EN
        // Watchdog: no mem_ready, forced completion 16 cycles after mem_valid
        chk("wd_err_before", 128'(timeout_err), 128'd0);
        req_valid = 2'b01;
        exp_req.push_back(mk(0));
        tick;
        exp_cpl.push_back('{ready: 2'b01, rdata: 32'hDEAD_BEEF});
        repeat (15) tick;
        chk("wd_no_early_ready", 128'(req_ready), 128'd0);
        tick;
        chk("wd_ready_pulse", 128'(req_ready), 128'(2'b01));
        chk("wd_err_not_yet", 128'(timeout_err), 128'd0);
        tick;
        req_valid = 2'b00;
        chk("wd_err_set",        128'(timeout_err), 128'd1);
        chk("wd_mem_valid_drop", 128'(mem_valid),   128'd0);
        repeat (3) tick;
        chk("wd_err_sticky", 128'(timeout_err), 128'd1);
`else
        chk("timeout_err_tied", 128'(timeout_err), 128'd0);
`endif

        repeat (2) tick;
        chk("exp_req_drained", 128'(exp_req.size()), 128'd0);
        chk("exp_cpl_drained", 128'(exp_cpl.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one native picorv32-style memory port (valid/ready/addr/wdata/wstrb/instr/rdata) among NREQ requesters, e.g. the scalar core fetch/LSU and the RVV vector load/store unit.
- Sits upstream of the AXI adapter that feeds axi4_memory.
- Grants one transaction at a time using round-robin priority.
- Holds the downstream request stable until completion, then routes the handshake back to the winner.

Parameters:
NREQ, 2, number of requesters (>=2)
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester request valid; held until req_ready
req_instr  input  NREQ  per-requester instruction-fetch flag
req_addr  input  NREQ*32  packed addresses, requester i at [32*i+31:32*i]
req_wdata  input  NREQ*32  packed write data
req_wstrb  input  NREQ*4  packed byte strobes; 0 = read
req_ready  output  NREQ  one-hot completion pulse
req_rdata  output  32  read data, broadcast, valid with req_ready
mem_valid  output  1  downstream request valid (registered)
mem_instr  output  1  downstream instruction flag (registered)
mem_addr  output  32  downstream address (registered)
mem_wdata  output  32  downstream write data (registered)
mem_wstrb  output  4  downstream strobes (registered)
mem_ready  input  1  downstream completion
mem_rdata  input  32  downstream read data
grant  output  NREQ  one-hot current owner; 0 when idle
timeout_err  output  1  sticky watchdog error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is resetn, synchronous and active-low.
- Reset values:
  - mem_valid=0, req_ready=0, grant=0, timeout_err=0.
  - mem_addr, mem_wdata, mem_wstrb and mem_instr = 0.
  - last_grant pointer = NREQ-1, so requester 0 wins first.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any req_valid is set, choose the first set bit searching upward from last_grant+1, modulo NREQ.
  - At the clock edge, latch the winner's addr/wdata/wstrb/instr into the mem_* registers.
  - Set mem_valid=1 and grant=onehot(winner); go to BUSY.
  - Latency: req_valid sampled at edge N gives mem_valid high after edge N.
- BUSY:
  - mem_* outputs stay frozen; new req_valid changes are ignored.
  - When mem_ready=1, req_ready[winner]=1 combinationally in the same cycle and req_rdata=mem_rdata (pass-through).
  - At that edge: mem_valid<=0, grant<=0, last_grant<=winner; go to IDLE.
- req_ready is never asserted outside BUSY&&mem_ready. req_rdata=mem_rdata at all times, qualified only by req_ready.
- One mandatory IDLE bubble separates transactions. Minimum transaction occupancy is 2 cycles when mem_ready arrives in the first BUSY cycle.
- mem_ready while IDLE: ignored, no req_ready pulse.
- Requester dropping req_valid before req_ready is a protocol violation. The downstream access still completes and the req_ready pulse is still delivered.
- Simultaneous requests: strict round-robin. A requester that just completed has lowest priority in the next arbitration.
- Single active requester: it is granted every second cycle at best, with no starvation of others.
- Reset mid-transaction: mem_valid drops at the next edge, with no req_ready pulse. The downstream slave must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_REQ_ARBITER_WATCHDOG_EN.
- When defined:
  - A 32-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES: force completion, with req_ready[winner]=1 for one cycle and req_rdata=32'hDEADBEEF.
  - At that edge: mem_valid<=0, timeout_err<=1 (sticky until reset); go to IDLE.
- When undefined: no counter, BUSY waits indefinitely, timeout_err tied 0.

Test Plan:
- Reset released, req_valid=2'b01, addr0=0x100, wstrb0=0, downstream ready after 3 cycles with rdata=0x12345678 -> mem_valid high 1 cycle after request, mem_addr=0x100; req_ready=2'b01 with req_rdata=0x12345678; grant returns 0.
- req_valid=2'b11 held continuously for 4 transactions -> grant sequence 01,10,01,10 with one IDLE bubble between each.
- Requester 1 write addr=0x200, wdata=0xCAFEF00D, wstrb=4'b0011 while requester 0 raises valid mid-BUSY -> mem_* frozen until mem_ready; requester 0 is then served next.
- Spurious mem_ready pulses during IDLE -> req_ready stays 0 and no state change.
- resetn low for 1 cycle during BUSY -> mem_valid=0 and grant=0 after the edge; the first post-reset grant goes to requester 0.
- With MEM_REQ_ARBITER_WATCHDOG_EN and TIMEOUT_CYCLES=16, mem_ready held 0 -> req_ready pulse with req_rdata=0xDEADBEEF 16 cycles after mem_valid rises; timeout_err=1 and stays 1.
